// File: rtl/layer1_pkg.sv
// layer1_pkg: shared types and arithmetic helpers for the first hidden-layer engine.
// Build option: define LAYER1_ROUND_EN for round-half-up requantization
// (truncating shift otherwise).
package layer1_pkg;

  // Controller phases; LOAD is the reset state.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FINISH  = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } l1_state_t;

  // Accumulator width large enough that a full frame of worst-case
  // products plus the bias can never overflow.
  function automatic int accWidth(input int inputW, input int weightW, input int nInputs);
    return inputW + weightW + 1 + $clog2(nInputs);
  endfunction

  // ReLU, requantizing shift and saturation applied to one lane's
  // biased sum. The result fits in nodeW bits; callers take the low bits.
  function automatic logic [31:0] requantize(input logic signed [63:0] s,
                                              input int shift,
                                              input int nodeW);
    logic signed [63:0] r;
    logic signed [63:0] maxv;
    if (s < 0) begin
      r = '0;
    end else begin
`ifdef LAYER1_ROUND_EN
      if (shift > 0) r = (s + (64'sd1 <<< (shift - 1))) >>> shift;
      else r = s;
`else
      r = s >>> shift;
`endif
    end
    maxv = (64'sd1 <<< nodeW) - 64'sd1;
    if (r > maxv) return 32'(maxv);
    else return 32'(r);
  endfunction

endpackage

// File: rtl/layer1_controller_lane.sv
// layer1_mac_lane: one hidden node. Holds the node's weight column and bias,
// accumulates pixel*weight for each accepted pixel and, on the FINISH step,
// loads the requantized result into its output field and clears the
// accumulator.
module layer1_mac_lane
  import layer1_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int INPUT_W   = 6,
  parameter int WEIGHT_W  = 5,
  parameter int NODE_W    = 6,
  parameter int OUT_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixelAccept,
  input  logic [INPUT_W-1:0]          pixel,
  input  logic [$clog2(N_INPUTS)-1:0] rowSel,
  input  logic                        weightWrite,
  input  logic                        biasWrite,
  input  logic [$clog2(N_INPUTS)-1:0] weightAddress,
  input  logic [WEIGHT_W-1:0]         weightIn,
  input  logic                        finishStep,
  output logic [NODE_W-1:0]           node
);

  localparam int ACC_W = accWidth(INPUT_W, WEIGHT_W, N_INPUTS);

  logic signed [WEIGHT_W-1:0] weightMem [N_INPUTS];
  logic signed [WEIGHT_W-1:0] bias;
  logic signed [ACC_W-1:0]    acc;

  logic signed [ACC_W-1:0] pixelExt;
  logic signed [ACC_W-1:0] weightExt;
  logic signed [ACC_W-1:0] biasExt;
  logic signed [ACC_W-1:0] product;
  logic signed [ACC_W-1:0] sumAcc;
  logic signed [63:0]      sum64;

  // Pixel is unsigned (zero-extend); weight and bias are two's complement.
  assign pixelExt  = {{(ACC_W-INPUT_W){1'b0}}, pixel};
  assign weightExt = {{(ACC_W-WEIGHT_W){weightMem[rowSel][WEIGHT_W-1]}}, weightMem[rowSel]};
  assign biasExt   = {{(ACC_W-WEIGHT_W){bias[WEIGHT_W-1]}}, bias};
  assign product   = pixelExt * weightExt;
  assign sumAcc    = acc + biasExt;
  assign sum64     = {{(64-ACC_W){sumAcc[ACC_W-1]}}, sumAcc};

  // Parameter writes, MAC accumulation and the FINISH result load. A write
  // on an accept edge lands at that edge while the MAC uses the old row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_INPUTS; k++) weightMem[k] <= '0;
      bias <= '0;
      acc  <= '0;
      node <= '0;
    end else begin
      if (weightWrite) weightMem[weightAddress] <= weightIn;
      if (biasWrite)   bias <= weightIn;
      if (finishStep) begin
        node <= NODE_W'(requantize(sum64, OUT_SHIFT, NODE_W));
        acc  <= '0;
      end else if (pixelAccept) begin
        acc <= acc + product;
      end
    end
  end

endmodule

// File: rtl/layer1_controller.sv
// layer1_controller: first hidden-layer engine. Streams one frame of pixels
// into N_NODES parallel MAC lanes, then presents the requantized node vector
// to Layer2 under a four-phase handshake.
// Build option: LAYER1_ROUND_EN selects round-half-up requantization.
//
// Handshakes:
//   input side  - a pixel transfers on any rising edge where
//                 inputsReady && inputsRecieved; inputsRecieved is high
//                 exactly while the controller is in LOAD.
//   output side - four-phase: outputsReady rises with a new layer2Input and
//                 holds until outputsRecieved is seen high; the next frame
//                 starts only after outputsRecieved is seen low again.
module layer1_controller
  import layer1_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int INPUT_W   = 6,
  parameter int WEIGHT_W  = 5,
  parameter int N_NODES   = 4,
  parameter int NODE_W    = 6,
  parameter int OUT_SHIFT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inputsReady,
  input  logic [INPUT_W-1:0]            pixelIn,
  output logic                          inputsRecieved,
  input  logic                          weightWriteEnable,
  input  logic                          biasWriteEnable,
  input  logic [$clog2(N_INPUTS)-1:0]   weightAddress,
  input  logic [N_NODES*WEIGHT_W-1:0]   writeIn,
  output logic [N_NODES*NODE_W-1:0]     layer2Input,
  output logic                          outputsReady,
  input  logic                          outputsRecieved,
  output l1_state_t                     dbgState
);

  localparam int CW = $clog2(N_INPUTS);

  l1_state_t     state;
  logic [CW-1:0] inputCount;
  logic          pixelAccept;
  logic          writeWindow;
  logic          finishStep;

  assign inputsRecieved = (state == LOAD);
  assign pixelAccept    = inputsReady && inputsRecieved;
  // Parameters may only change between frames, before any pixel is taken.
  assign writeWindow    = (state == LOAD) && (inputCount == '0);
  assign finishStep     = (state == FINISH);
  assign dbgState       = state;

  // Frame sequencing, pixel counting and the registered outputsReady flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LOAD;
      inputCount   <= '0;
      outputsReady <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (pixelAccept) begin
            if (inputCount == CW'(N_INPUTS - 1)) begin
              inputCount <= '0;
              state      <= FINISH;
            end else begin
              inputCount <= inputCount + CW'(1);
            end
          end
        end
        FINISH: begin
          outputsReady <= 1'b1;
          state        <= PRESENT;
        end
        PRESENT: begin
          if (outputsRecieved) begin
            outputsReady <= 1'b0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          if (!outputsRecieved) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  for (genvar g = 0; g < N_NODES; g++) begin : g_lane
    layer1_mac_lane #(
      .N_INPUTS (N_INPUTS),
      .INPUT_W  (INPUT_W),
      .WEIGHT_W (WEIGHT_W),
      .NODE_W   (NODE_W),
      .OUT_SHIFT(OUT_SHIFT)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .pixelAccept  (pixelAccept),
      .pixel        (pixelIn),
      .rowSel       (inputCount),
      .weightWrite  (weightWriteEnable && writeWindow),
      .biasWrite    (biasWriteEnable && writeWindow),
      .weightAddress(weightAddress),
      .weightIn     (writeIn[g*WEIGHT_W +: WEIGHT_W]),
      .finishStep   (finishStep),
      .node         (layer2Input[g*NODE_W +: NODE_W])
    );
  end

endmodule

// File: doc/layer1_controller.md
# layer1_controller

First hidden-layer engine of the classifier, directly upstream of `Layer2_Controller`.
- Accepts one frame of `N_INPUTS` unsigned pixels, one per cycle, over a valid/ready handshake.
- Runs `N_NODES` signed multiply-accumulate lanes in parallel, then adds bias, applies ReLU, requantizes and saturates.
- Presents the packed node vector as `layer2Input` under a four-phase `outputsReady`/`outputsRecieved` handshake.

## Interface
Parameters:
- `N_INPUTS`, 16: pixels per frame.
- `INPUT_W`, 6: pixel width, unsigned.
- `WEIGHT_W`, 5: weight and bias width, two's complement.
- `N_NODES`, 4: hidden nodes (lanes).
- `NODE_W`, 6: output node width, unsigned.
- `OUT_SHIFT`, 4: requantization right shift.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `inputsReady` in 1: `pixelIn` valid.
- `pixelIn` in `INPUT_W`: current pixel.
- `inputsRecieved` out 1: ready to accept a pixel.
- `weightWriteEnable` in 1: write the weight row selected by `weightAddress`.
- `biasWriteEnable` in 1: write all biases.
- `weightAddress` in `$clog2(N_INPUTS)`: input index of the weight row.
- `writeIn` in `N_NODES*WEIGHT_W`: lane i at `[i*WEIGHT_W +: WEIGHT_W]`.
- `layer2Input` out `N_NODES*NODE_W`: node i at `[i*NODE_W +: NODE_W]`.
- `outputsReady` out 1: `layer2Input` valid.
- `outputsRecieved` in 1: downstream acknowledge.

## Operation
- States: `LOAD`, `FINISH`, `PRESENT`, `RELEASE`. Reset state is `LOAD`.
- Reset values:
  - `inputCount`, accumulators, weights, biases and the output register are 0.
  - `outputsReady` is 0.
  - `inputsRecieved` is 1, because it is decoded as state==`LOAD`.
- `LOAD`: a pixel is accepted on any edge where `inputsReady && inputsRecieved`.
  - Each lane adds `pixel * weight[inputCount][i]` to its accumulator.
  - The pixel is zero-extended and the weight sign-extended.
  - `inputCount` increments.
  - On acceptance of pixel `N_INPUTS-1`, `inputCount` wraps to 0 and the state moves to `FINISH`.
- `FINISH` (exactly 1 cycle), per lane:
  - s = acc + sign-extended bias.
  - r = (s<0) ? 0 : s>>>`OUT_SHIFT`.
  - Output field = min(r, 2^`NODE_W`-1).
  - The output register loads the result, accumulators clear, and the state moves to `PRESENT`.
- `PRESENT`: `outputsReady`=1 and `layer2Input` is held stable. When `outputsRecieved`=1, the state moves to `RELEASE`.
- `RELEASE`: `outputsReady`=0. When `outputsRecieved`=0, the state returns to `LOAD`.
- The output register keeps the last result until the next `FINISH`.
- Accumulator width is `ACC_W`=`INPUT_W`+`WEIGHT_W`+1+`$clog2(N_INPUTS)`, so no overflow is possible.
- Weight and bias writes are honoured only in `LOAD` with `inputCount`==0; otherwise they are ignored.
  - A write and a pixel accept may occur on the same edge. The MAC then uses the pre-edge weights, and the write lands at that edge.
  - Simultaneous weight and bias writes both take effect.
- `inputsReady` while not in `LOAD` has no effect, and no pixel is dropped.
- Asserting reset mid-frame or mid-handshake returns the block to the reset values immediately, without waiting for a clock edge.

## Timing
- Throughput: one pixel per cycle when `inputsReady` is held high.
- Edge E accepts the last pixel; at edge E+1 (the `FINISH` edge) `layer2Input` updates and `outputsReady` rises.
- Minimum frame-to-frame period: `N_INPUTS`+1 cycles, plus the handshake.
- `outputsReady` falls one edge after `outputsRecieved` is sampled high.
- `inputsRecieved` rises one edge after `outputsRecieved` is sampled low.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.

## Configuration
- `LAYER1_ROUND_EN` defined: in `FINISH`, 2^(`OUT_SHIFT`-1) is added to s (when s≥0) before the shift, giving round-half-up.
- `LAYER1_ROUND_EN` undefined: truncating shift.
- Saturation and ReLU are identical in both builds.

## Structure
- Package `layer1_pkg`:
  - State enum `l1_state_t`.
  - `ACC_W` computation function.
  - Requantize/ReLU/saturate function shared by all lanes.
- Sub-module `layer1_mac_lane`: one per node, generated `N_NODES` times. It contains:
  - that lane's weight column and bias register;
  - the accumulator;
  - the `FINISH` arithmetic.
- The top level holds the state machine, `inputCount` and the handshake.

## Test plan
- All weights +1, biases 0, 16 pixels of 63 → acc 1008 → node 63 each; `layer2Input`=24'hFFFFFF; `outputsReady` rises 1 edge after the last accept.
- All weights -1, biases 0, pixels 63 → every node 0; `layer2Input`=24'h000000.
- Weights +1, biases 0, pixels all 1 → acc 16 → node 1 each; `layer2Input`=24'h041041.
- Weights +1, biases 0, one pixel 8 and the rest 0:
  - without `LAYER1_ROUND_EN`, 24'h000000;
  - with it, 24'h041041.
- Hold `outputsRecieved` low for 10 cycles after `outputsReady`:
  - `outputsReady` and `layer2Input` stay stable;
  - `inputsRecieved`=0 and no pixels are accepted;
  - after the ack high then low, `inputsRecieved` returns to 1.
- Assert `reset` low after 5 pixels are accepted:
  - all outputs take their reset values immediately;
  - weights read back 0;
  - after reloading weights, a fresh frame yields its expected value.
- Attempt a weight write while `inputCount`=3 → the write is ignored and the frame result is unchanged.
